memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Multi-requester RAM arbiter sitting between the per-CPU caches and the single-ported RAM model. It generalises single-CPU memory control to `CPUS` processors, each with one instruction and one data port. Arbitration is round-robin across all `2*CPUS` requesters. A registered grant FSM holds the RAM for one owner until the RAM reports `ACCESS`.

## Interface
Parameters:
- `CPUS`, default 2: number of processors; requesters = `2*CPUS`, indexed `r = 2*cpu + 0` (data) and `2*cpu + 1` (instr).
- `IW`, default `$clog2(2*CPUS)` (minimum 1): requester index width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset: synchronous, active-low, sampled on `CLK` rising edge.
- `iREN`  in  `[CPUS]`  instruction read request per CPU.
- `iaddr`  in  `word_t[CPUS]`  instruction address.
- `dREN`, `dWEN`  in  `[CPUS]`  data read / write request.
- `daddr`, `dstore`  in  `word_t[CPUS]`  data address / write data.
- `iwait`, `dwait`  out  `[CPUS]`  high = stall; low for exactly the completing cycle of that port.
- `iload`, `dload`  out  `word_t[CPUS]`  each is `ramload`, broadcast to all.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  `word_t`  RAM address / write data.
- `ramload`  in  `word_t`  RAM read data.
- `ramstate`  in  `ramstate_t`  `FREE` / `BUSY` / `ACCESS` / `ERROR`.

## Operation
- Requester `r` is active when:
  - data: `dREN | dWEN`;
  - instr: `iREN`.
- If `dREN` and `dWEN` are both high, the request is a write.
- FSM states:
  - `IDLE`: no owner; `ramREN = ramWEN = 0`; `ramaddr = ramstore = 0`. If any requester is active, select the first active index at or after `ptr` (cyclic order `ptr, ptr+1 … 2*CPUS-1, 0 …`), register it into `owner`, and go to `GRANT`. Otherwise stay.
  - `GRANT`: drive RAM from `owner`.
    - Data owner: `ramaddr = daddr`, `ramWEN = dWEN`, `ramREN = dREN & ~dWEN`, `ramstore = dstore`.
    - Instr owner: `ramaddr = iaddr`, `ramREN = 1`.
    - When `ramstate == ACCESS`, drive the owner's wait low (combinational, same cycle), set `ptr <= owner + 1` (wrapping at `2*CPUS`), and go to `IDLE`.
    - `ERROR`, `BUSY` and `FREE` all hold in `GRANT` with wait high.
- Abort: if the owner's request drops while in `GRANT`, go to `IDLE` next edge with no wait-low pulse, and set `ptr <= owner + 1`.
- Every non-owner wait is high in every cycle.

## Timing
- Reset state:
  - `state = IDLE`, `ptr = 0`, `owner = 0`.
  - All `iwait`/`dwait` = 1; `ramREN = ramWEN = 0`; `ramaddr = ramstore = 0`.
  - `iload`/`dload` follow `ramload`.
- Latency: a request first visible in cycle 0 (IDLE) is granted at edge 1. With `ACCESS` in cycle 1, wait is low in cycle 1. Minimum is 2 cycles per transaction; one idle cycle between back-to-back grants.
- Requesters must hold request, address and data stable until their wait goes low.
- Fairness: with all `2*CPUS` requesters continuously active, each is served once per `2*CPUS` transactions.
- Simultaneous new requests in `IDLE` are resolved purely by `ptr`. There is no fixed data-over-instruction priority across CPUs; within one CPU at `ptr == 2*cpu`, data wins.
- `nRST` low mid-transaction: next edge forces the reset state, and the RAM strobes drop that same edge.
- `ptr` and `owner` are `IW`-bit; wrap is explicit, not by overflow, when `2*CPUS` is not a power of 2.

## Structure
- `word_t` and `ramstate_t` come from `cpu_types_pkg`.
- Add `arb_state_t` (`IDLE`, `GRANT`) to `cpu_types_pkg`.
- One sub-module, `rr_picker`: combinational, `N`-wide request vector plus `ptr` in; `valid` and index out. Implemented as a doubled-vector priority scan.
- The FSM, RAM muxing and wait decode stay in `memory_arbiter`.

## Test plan
- Reset: hold `nRST = 0` 3 cycles with all requests high → all waits 1, `ramREN = ramWEN = 0`, `ramaddr = 0`.
- Single fetch: `CPUS = 2`, `iREN[1] = 1`, `iaddr[1] = 0x40`, RAM returns `ACCESS` at first `GRANT` cycle → `ramaddr = 0x40`, `ramREN = 1`; `iwait[1] = 0` in cycle 1 only; `iload[1] = ramload`.
- Write precedence: `dREN[0] = dWEN[0] = 1`, `daddr = 0x100`, `dstore = 0xDEADBEEF` → `ramWEN = 1`, `ramREN = 0`, `ramstore = 0xDEADBEEF`; `dwait[0]` low on `ACCESS`.
- Round-robin: all 4 requesters held high, `ACCESS` every `GRANT` cycle → service order `d0, i0, d1, i1, d0`; each wait pulses low once per 8 cycles.
- Abort and stall: grant `d1`, hold `ramstate = BUSY` 5 cycles, then drop `dREN[1]` → `IDLE` next edge, no `dwait[1]` low pulse, next grant goes to `i1`.
- Reset mid-grant: assert `nRST = 0` during `GRANT` of `i0` → strobes 0 after the edge; after release, the first grant goes to index 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state and arbiter FSM state.
// Also holds the cyclic increment used for the round-robin pointer.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Explicit wrap so non-power-of-2 requester counts never overflow into a hole.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// found by scanning a doubled request vector rotated down by ptr.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot;

   assign dbl = {req, req};
   assign rot = dbl >> ptr;

   always_comb begin
      int unsigned pos;
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!valid && rot[i]) begin
            valid = 1'b1;
            pos   = 32'(ptr) + i;
            if (pos >= N) pos = pos - N;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving 2*CPUS cache ports (data/instr per CPU) turns on a
// single-ported RAM; one owner holds the RAM until it reports ACCESS.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2,
   parameter int IW   = ($clog2(2 * CPUS) < 1) ? 1 : $clog2(2 * CPUS)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [CPUS-1:0]   iREN,
   input  word_t             iaddr    [CPUS],
   input  logic [CPUS-1:0]   dREN,
   input  logic [CPUS-1:0]   dWEN,
   input  word_t             daddr    [CPUS],
   input  word_t             dstore   [CPUS],
   output logic [CPUS-1:0]   iwait,
   output logic [CPUS-1:0]   dwait,
   output word_t             iload    [CPUS],
   output word_t             dload    [CPUS],
   output logic              ramREN,
   output logic              ramWEN,
   output word_t             ramaddr,
   output word_t             ramstore,
   input  word_t             ramload,
   input  ramstate_t         ramstate
);

   localparam int N = 2 * CPUS;

   arb_state_t    state, state_n;
   logic [IW-1:0] owner, owner_n;
   logic [IW-1:0] ptr, ptr_n;

   logic [N-1:0]  req;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          owner_active;

   always_comb begin
      for (int unsigned c = 0; c < CPUS; c++) begin
         req[2*c]     = dREN[c] | dWEN[c];
         req[2*c + 1] = iREN[c];
         iload[c]     = ramload;
         dload[c]     = ramload;
      end
   end

   assign owner_active = req[owner];

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      ptr_n    = ptr;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               owner_n = pick_idx;
               state_n = GRANT;
            end
         end

         GRANT: begin
            // A dropped request is an abort: release without driving the RAM
            // or pulsing wait, even if the RAM happens to report ACCESS.
            if (!owner_active) begin
               ptr_n   = IW'(rr_next(32'(owner), N));
               state_n = IDLE;
            end else begin
               for (int unsigned c = 0; c < CPUS; c++) begin
                  if (owner == IW'(2 * c)) begin
                     ramaddr  = daddr[c];
                     ramstore = dstore[c];
                     ramWEN   = dWEN[c];
                     ramREN   = dREN[c] & ~dWEN[c];
                     if (ramstate == ACCESS) dwait[c] = 1'b0;
                  end
                  if (owner == IW'(2 * c + 1)) begin
                     ramaddr = iaddr[c];
                     ramREN  = 1'b1;
                     if (ramstate == ACCESS) iwait[c] = 1'b0;
                  end
               end
               if (ramstate == ACCESS) begin
                  ptr_n   = IW'(rr_next(32'(owner), N));
                  state_n = IDLE;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with CPUS=2: reset, single fetch, write
// precedence, round-robin order, abort under stall and reset mid-grant.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic       CLK;
   logic       nRST;
   logic [1:0] iREN, dREN, dWEN;
   word_t      iaddr  [2];
   word_t      daddr  [2];
   word_t      dstore [2];
   logic [1:0] iwait, dwait;
   word_t      iload  [2];
   word_t      dload  [2];
   logic       ramREN, ramWEN;
   word_t      ramaddr, ramstore, ramload;
   ramstate_t  ramstate;

   int passed = 0;
   int total  = 0;

   memory_arbiter #(.CPUS(2)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .iwait    (iwait),
      .dwait    (dwait),
      .iload    (iload),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      logic [31:0] rr_addr [5];
      logic [1:0]  rr_dw   [5];
      logic [1:0]  rr_iw   [5];

      nRST = 1'b0;
      iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
      iaddr[0] = 32'hB0; iaddr[1] = 32'hD0;
      daddr[0] = 32'hA0; daddr[1] = 32'hC0;
      dstore[0] = 32'h0; dstore[1] = 32'h0;
      ramload  = 32'h1234_5678;
      ramstate = FREE;

      // reset held 3 cycles with every request high
      repeat (3) cyc();
      #1;
      chk("rst_iwait",   iwait,   32'h3);
      chk("rst_dwait",   dwait,   32'h3);
      chk("rst_ramREN",  ramREN,  32'h0);
      chk("rst_ramWEN",  ramWEN,  32'h0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_dload0",  dload[0], 32'h1234_5678);

      // single fetch by i1
      iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
      nRST = 1'b1;
      cyc();
      iREN[1] = 1'b1; iaddr[1] = 32'h40; ramstate = ACCESS;
      #1;
      chk("fetch_idle_ren", ramREN, 32'h0);
      chk("fetch_idle_iw",  iwait,  32'h3);
      cyc();
      chk("fetch_addr",  ramaddr,  32'h40);
      chk("fetch_ren",   ramREN,   32'h1);
      chk("fetch_wen",   ramWEN,   32'h0);
      chk("fetch_iwait", iwait,    32'h1);
      chk("fetch_dwait", dwait,    32'h3);
      chk("fetch_iload", iload[1], 32'h1234_5678);
      cyc();
      iREN[1] = 1'b0;
      #1;
      chk("fetch_after_iw",  iwait,  32'h3);
      chk("fetch_after_ren", ramREN, 32'h0);

      // round-robin with all four requesters held, ptr starts at 0
      iaddr[1] = 32'hD0;
      iREN = 2'b11; dREN = 2'b11; dWEN = 2'b00;
      rr_addr[0] = 32'hA0; rr_dw[0] = 2'b10; rr_iw[0] = 2'b11;
      rr_addr[1] = 32'hB0; rr_dw[1] = 2'b11; rr_iw[1] = 2'b10;
      rr_addr[2] = 32'hC0; rr_dw[2] = 2'b01; rr_iw[2] = 2'b11;
      rr_addr[3] = 32'hD0; rr_dw[3] = 2'b11; rr_iw[3] = 2'b01;
      rr_addr[4] = 32'hA0; rr_dw[4] = 2'b10; rr_iw[4] = 2'b11;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("rr%0d_addr", k),  ramaddr, rr_addr[k]);
         chk($sformatf("rr%0d_dwait", k), dwait,   32'(rr_dw[k]));
         chk($sformatf("rr%0d_iwait", k), iwait,   32'(rr_iw[k]));
         cyc();
         chk($sformatf("rr%0d_idle", k), ramREN, 32'h0);
      end
      iREN = 2'b00; dREN = 2'b00;

      // write precedence: d0 with both strobes set (ptr now 1)
      dREN[0] = 1'b1; dWEN[0] = 1'b1;
      daddr[0] = 32'h100; dstore[0] = 32'hDEAD_BEEF; ramstate = BUSY;
      cyc();
      chk("wr_wen",   ramWEN,   32'h1);
      chk("wr_ren",   ramREN,   32'h0);
      chk("wr_addr",  ramaddr,  32'h100);
      chk("wr_store", ramstore, 32'hDEAD_BEEF);
      chk("wr_busy_dwait", dwait, 32'h3);
      ramstate = ACCESS;
      #1;
      chk("wr_acc_dwait", dwait, 32'h2);
      cyc();
      dREN = 2'b00; dWEN = 2'b00;
      #1;
      chk("wr_after_dwait", dwait, 32'h3);

      // abort under stall: d1 granted (ptr 1), BUSY for 5 cycles, then dropped
      dREN[1] = 1'b1; daddr[1] = 32'h200; ramstate = BUSY;
      cyc();
      chk("ab_addr", ramaddr, 32'h200);
      chk("ab_ren",  ramREN,  32'h1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("ab_stall%0d_dwait", k), dwait,  32'h3);
         chk($sformatf("ab_stall%0d_ren", k),   ramREN, 32'h1);
      end
      dREN[1] = 1'b0; iREN = 2'b11;
      #1;
      chk("ab_drop_dwait", dwait, 32'h3);
      cyc();
      chk("ab_idle_ren", ramREN, 32'h0);
      cyc();
      chk("ab_next_addr", ramaddr, 32'hD0);
      ramstate = ACCESS;
      #1;
      chk("ab_next_iwait", iwait, 32'h1);
      cyc();
      iREN[1] = 1'b0; ramstate = BUSY;

      // reset mid-grant of i0 (ptr back to 0 after i1)
      cyc();
      chk("rg_addr", ramaddr, 32'hB0);
      chk("rg_ren",  ramREN,  32'h1);
      nRST = 1'b0;
      cyc();
      chk("rg_rst_ren",   ramREN,  32'h0);
      chk("rg_rst_addr",  ramaddr, 32'h0);
      chk("rg_rst_iwait", iwait,   32'h3);
      daddr[0] = 32'hA0; dREN = 2'b11;
      nRST = 1'b1;
      cyc();
      chk("rg_first_addr", ramaddr, 32'hA0);
      chk("rg_first_ren",  ramREN,  32'h1);
      ramstate = ACCESS;
      #1;
      chk("rg_first_dwait", dwait, 32'h2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
